// File: rtl/req_encoder_pkg.sv
// Shared types and helpers for the sequential request encoder.
package req_encoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int N_DEF = 4;

  // True when exactly one bit is set; callers zero-extend into 32 bits.
  function automatic logic pop_is_one(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/req_encoder_prio_enc.sv
// Combinational highest-set-bit finder with an any-set flag.
module prio_enc #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] v_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // The loop runs upward, so the highest set bit is the last to write idx_o.
  always_comb begin
    idx_o = '0;
    any_o = |v_i;
    for (int i = 0; i < N; i++) begin
      if (v_i[i]) idx_o = W'(i);
    end
  end

endmodule

// File: rtl/req_encoder.sv
// Captures a multi-hot request word and emits its set indices, highest first.
// Define REQ_ENCODER_ZERO_EN to emit a flagged beat for an all-zero word.
module req_encoder
  import req_encoder_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] y,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] w,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         last,
`ifdef REQ_ENCODER_ZERO_EN
  output logic         zero,
`endif
  output logic         busy
);

  state_e       state_q;
  logic [N-1:0] pending_q;
  logic         zero_q;
  logic [W-1:0] hi_idx;
  logic         hi_any;
  logic         accept;
  logic         beat;
  logic [N-1:0] pending_d;

  prio_enc #(.N(N), .W(W)) u_prio (
    .v_i  (pending_q),
    .idx_o(hi_idx),
    .any_o(hi_any)
  );

  assign in_ready  = (state_q == IDLE) & en;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DRAIN);
  assign beat      = out_valid & out_ready;
  assign busy      = (state_q == DRAIN);
  assign w         = hi_idx;
  // A zero beat has no pending bits but is still the final beat of its word.
  assign last      = out_valid & (pop_is_one(32'(pending_q)) | zero_q);
  assign pending_d = pending_q & ~({{(N-1){1'b0}}, 1'b1} << hi_idx);

`ifdef REQ_ENCODER_ZERO_EN
  assign zero = zero_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (y != '0) begin
              pending_q <= y;
              zero_q    <= 1'b0;
              state_q   <= DRAIN;
            end else begin
`ifdef REQ_ENCODER_ZERO_EN
              pending_q <= '0;
              zero_q    <= 1'b1;
              state_q   <= DRAIN;
`else
              state_q   <= IDLE;
`endif
            end
          end
        end
        DRAIN: begin
          if (beat) begin
            pending_q <= hi_any ? pending_d : '0;
            if (last) begin
              state_q <= IDLE;
              zero_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_encoder.sv
// Directed bench for req_encoder with N = 4.
module tb_req_encoder;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [N-1:0] y;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] w;
  logic         out_valid;
  logic         out_ready;
  logic         last;
  logic         busy;
`ifdef REQ_ENCODER_ZERO_EN
  logic         zero;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  req_encoder #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .y        (y),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .w        (w),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .last     (last),
`ifdef REQ_ENCODER_ZERO_EN
    .zero     (zero),
`endif
    .busy     (busy)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; y = '0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || w !== 2'd0 || last !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: out_valid=%b busy=%b w=%0d last=%b in_ready=%b, want 0 0 0 0 1",
               out_valid, busy, w, last, in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_multi_hot();
    logic [W-1:0] exp_w [3] = '{2'd3, 2'd1, 2'd0};
    logic         exp_l [3] = '{1'b0, 1'b0, 1'b1};
    y = 4'b1011; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; y = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b1 || w !== exp_w[i] || last !== exp_l[i] || in_ready !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL multi_hot beat%0d: v=%b w=%0d last=%b rdy=%b busy=%b, want 1 %0d %b 0 1",
                 i, out_valid, w, last, in_ready, busy, exp_w[i], exp_l[i]);
      end
      tick();
    end
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL multi_hot_done: v=%b rdy=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    y = 4'b0110; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; y = '0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || w !== 2'd2 || last !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure_hold%0d: v=%b w=%0d last=%b, want 1 2 0", i, out_valid, w, last);
      end
      if (i < 3) tick();
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || w !== 2'd1 || last !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_second: v=%b w=%0d last=%b, want 1 1 1", out_valid, w, last);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_done: v=%b busy=%b, want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_enable();
    en = 1'b0; y = 4'b0100; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_gate_ready: in_ready=%b, want 0", in_ready);
    end
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_no_capture: v=%b busy=%b, want 0 0", out_valid, busy);
    end
    en = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL enable_ready: in_ready=%b, want 1", in_ready);
    end
    tick();
    in_valid = 1'b0; y = '0;
    vectors++;
    if (out_valid !== 1'b1 || w !== 2'd2 || last !== 1'b1) begin
      miscompares++;
      $display("FAIL enable_single: v=%b w=%0d last=%b, want 1 2 1", out_valid, w, last);
    end
    tick();
    // Drop en right after capture; the drain must carry on regardless.
    y = 4'b1111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; y = '0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b1 || w !== 2'(3 - i) || last !== (i == 3)) begin
        miscompares++;
        $display("FAIL enable_drain%0d: v=%b w=%0d last=%b, want 1 %0d %b",
                 i, out_valid, w, last, 3 - i, (i == 3));
      end
      tick();
    end
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_drain_done: v=%b busy=%b rdy=%b, want 0 0 0", out_valid, busy, in_ready);
    end
    en = 1'b1;
    tick();
  endtask

  task automatic test_zero_word();
    y = 4'b0000; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_ready: in_ready=%b, want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
`ifdef REQ_ENCODER_ZERO_EN
    vectors++;
    if (out_valid !== 1'b1 || w !== 2'd0 || last !== 1'b1 || zero !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_beat: v=%b w=%0d last=%b zero=%b, want 1 0 1 1", out_valid, w, last, zero);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || zero !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_done: v=%b busy=%b zero=%b, want 0 0 0", out_valid, busy, zero);
    end
`else
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_dropped%0d: v=%b busy=%b, want 0 0", i, out_valid, busy);
      end
      tick();
    end
`endif
  endtask

  task automatic test_reset_mid_drain();
    int bad_beats = 0;
    y = 4'b1111; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; y = '0;
    vectors++;
    if (out_valid !== 1'b1 || w !== 2'd3) begin
      miscompares++;
      $display("FAIL rst_mid_first: v=%b w=%0d, want 1 3", out_valid, w);
    end
    tick();
    rst_n = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_clear: v=%b busy=%b, want 0 0", out_valid, busy);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid) bad_beats++;
    end
    vectors++;
    if (bad_beats !== 0) begin
      miscompares++;
      $display("FAIL rst_mid_no_beats: beats=%0d, want 0", bad_beats);
    end
  endtask

  initial begin
    test_reset();
    test_multi_hot();
    test_backpressure();
    test_enable();
    test_zero_word();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
